// File: rtl/match_window_counter.sv
// match_window_counter: counts single-cycle match pulses from the pair-match
// detector over a programmable window of clock cycles. At the end of each
// window it presents the count and its status flags to the host.
//
// Ports:
//   clk, rst       rising-edge clock; asynchronous active-high reset
//   en             run enable; a window starts when it is high in IDLE or on ack in HOLD
//   match_in       match pulse (detector's registered outp)
//   win_len        window length in cycles, sampled at window start (0 acts as 1)
//   threshold      compare value, sampled at window start
//   count_ack      host acknowledge of the presented result (HOLD only)
//   count_out      saturated match count of the last completed window
//   count_valid    result pending, held until acknowledged
//   over_thresh    count_out >= latched threshold for the presented result
//   overflow       accumulator saturated during the presented window
//   dropped        sticky: a match arrived in HOLD; cleared by rst or the next window start
//   busy           high while a window is counting
module match_window_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             match_in,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] threshold,
  input  logic             count_ack,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             over_thresh,
  output logic             overflow,
  output logic             dropped,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] ACC_MAX = {CNT_W{1'b1}};
  localparam logic [WIN_W-1:0] REM_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [WIN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic             win_ovf_q, win_ovf_d;
  logic [CNT_W-1:0] count_out_q, count_out_d;
  logic             count_valid_q, count_valid_d;
  logic             over_thresh_q, over_thresh_d;
  logic             overflow_q, overflow_d;
  logic             dropped_q, dropped_d;

  // Saturating add: a match while already at maximum holds the value and
  // flags the window as overflowed.
  logic             add_ovf;
  logic [CNT_W-1:0] acc_next;
  logic [WIN_W-1:0] rem_start;
  logic             start_win;

  assign add_ovf   = (acc_q == ACC_MAX) & match_in;
  assign acc_next  = add_ovf ? acc_q : (acc_q + {{(CNT_W-1){1'b0}}, match_in});
  // A zero length still gives a one-cycle window.
  assign rem_start = (win_len == '0) ? REM_ONE : win_len;

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    rem_d         = rem_q;
    thr_d         = thr_q;
    win_ovf_d     = win_ovf_q;
    count_out_d   = count_out_q;
    count_valid_d = count_valid_q;
    over_thresh_d = over_thresh_q;
    overflow_d    = overflow_q;
    dropped_d     = dropped_q;
    start_win     = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) start_win = 1'b1;
      end
      COUNT: begin
        if (!en) begin
          // Abort: the partial count is discarded, the last result is kept.
          state_d   = IDLE;
          acc_d     = '0;
          rem_d     = '0;
          win_ovf_d = 1'b0;
        end else if (rem_q == REM_ONE) begin
          // Last window edge: this edge's match is part of the result.
          acc_d         = acc_next;
          rem_d         = '0;
          count_out_d   = acc_next;
          over_thresh_d = (acc_next >= thr_q);
          overflow_d    = win_ovf_q | add_ovf;
          count_valid_d = 1'b1;
          state_d       = HOLD;
        end else begin
          acc_d     = acc_next;
          rem_d     = rem_q - REM_ONE;
          win_ovf_d = win_ovf_q | add_ovf;
        end
      end
      HOLD: begin
        if (match_in) dropped_d = 1'b1;
        if (count_ack) begin
          count_valid_d = 1'b0;
          if (en) start_win = 1'b1;
          else    state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Window start clears dropped even if a match lands on the same edge.
    if (start_win) begin
      state_d   = COUNT;
      rem_d     = rem_start;
      acc_d     = '0;
      thr_d     = threshold;
      win_ovf_d = 1'b0;
      dropped_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      rem_q         <= '0;
      thr_q         <= '0;
      win_ovf_q     <= 1'b0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      over_thresh_q <= 1'b0;
      overflow_q    <= 1'b0;
      dropped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      rem_q         <= rem_d;
      thr_q         <= thr_d;
      win_ovf_q     <= win_ovf_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
      over_thresh_q <= over_thresh_d;
      overflow_q    <= overflow_d;
      dropped_q     <= dropped_d;
    end
  end

  assign count_out   = count_out_q;
  assign count_valid = count_valid_q;
  assign over_thresh = over_thresh_q;
  assign overflow    = overflow_q;
  assign dropped     = dropped_q;
  assign busy        = (state_q == COUNT);

endmodule

// File: tb/tb_match_window_counter.sv
module tb_match_window_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        match_in = 1'b0;
  logic [15:0] win_len = '0;
  logic [7:0]  threshold = '0;
  logic [3:0]  threshold4 = '0;
  logic        count_ack = 1'b0;

  logic [7:0]  count_out;
  logic        count_valid, over_thresh, overflow, dropped, busy;
  logic [3:0]  count_out4;
  logic        count_valid4, over_thresh4, overflow4, dropped4, busy4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  match_window_counter #(.CNT_W(8), .WIN_W(16)) u_dut (
    .clk(clk), .rst(rst), .en(en), .match_in(match_in), .win_len(win_len),
    .threshold(threshold), .count_ack(count_ack), .count_out(count_out),
    .count_valid(count_valid), .over_thresh(over_thresh), .overflow(overflow),
    .dropped(dropped), .busy(busy)
  );

  match_window_counter #(.CNT_W(4), .WIN_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .match_in(match_in), .win_len(win_len),
    .threshold(threshold4), .count_ack(count_ack), .count_out(count_out4),
    .count_valid(count_valid4), .over_thresh(over_thresh4), .overflow(overflow4),
    .dropped(dropped4), .busy(busy4)
  );

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; match_in = 1'b0; count_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; match_in = 1'b0; count_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if ({count_out, count_valid, over_thresh, overflow, dropped, busy} !== 13'd0) begin
      errors++; $display("FAIL reset_outputs: got %h exp 0", {count_out, count_valid, over_thresh, overflow, dropped, busy}); end
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %0b exp 0", busy); end
  endtask

  // Matches on window cycles 2, 4, 8; mid-window input changes must be ignored.
  task automatic test_basic();
    en = 1'b1; win_len = 16'd8; threshold = 8'd3; match_in = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b exp 1", busy); end
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) begin
        checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b exp 0", count_valid); end
      end
      match_in = (i == 2 || i == 4 || i == 8);
      if (i == 3) begin win_len = 16'd3; threshold = 8'd200; end
      @(negedge clk);
    end
    match_in = 1'b0;
    checks++; if (count_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b exp 1", count_valid); end
    checks++; if (count_out !== 8'd3) begin errors++; $display("FAIL basic_count: got %0d exp 3", count_out); end
    checks++; if (over_thresh !== 1'b1) begin errors++; $display("FAIL basic_over: got %0b exp 1", over_thresh); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %0b exp 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %0b exp 0", busy); end
  endtask

  task automatic test_hold_handshake();
    for (int i = 0; i < 20; i++) begin
      count_ack = 1'b0; match_in = (i % 3 == 0);
      @(negedge clk);
      checks++; if (count_out !== 8'd3 || count_valid !== 1'b1) begin
        errors++; $display("FAIL hold_stable: cycle %0d got count=%0d valid=%0b exp 3/1", i, count_out, count_valid); end
    end
    checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL hold_dropped: got %0b exp 1", dropped); end
    count_ack = 1'b1; en = 1'b1; win_len = 16'd8; threshold = 8'd3; match_in = 1'b1;
    @(negedge clk);
    count_ack = 1'b0;
    checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL ack_valid: got %0b exp 0", count_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ack_restart: got %0b exp 1", busy); end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL ack_dropped_clear: got %0b exp 0", dropped); end
    for (int i = 1; i <= 8; i++) begin
      match_in = (i <= 5);
      @(negedge clk);
    end
    match_in = 1'b0;
    checks++; if (count_valid !== 1'b1 || count_out !== 8'd5) begin
      errors++; $display("FAIL second_window: got valid=%0b count=%0d exp 1/5", count_valid, count_out); end
    count_ack = 1'b1; en = 1'b0;
    @(negedge clk);
    count_ack = 1'b0;
    checks++; if (count_valid !== 1'b0 || busy !== 1'b0 || count_out !== 8'd5) begin
      errors++; $display("FAIL ack_to_idle: got valid=%0b busy=%0b count=%0d exp 0/0/5", count_valid, busy, count_out); end
  endtask

  task automatic test_abort();
    en = 1'b1; win_len = 16'd10; threshold = 8'd0;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin match_in = 1'b1; @(negedge clk); end
    en = 1'b0; match_in = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || count_valid !== 1'b0 || count_out !== 8'd5) begin
      errors++; $display("FAIL abort: got busy=%0b valid=%0b count=%0d exp 0/0/5", busy, count_valid, count_out); end
    for (int i = 0; i < 3; i++) @(negedge clk);
    checks++; if (dropped !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_ignore: got dropped=%0b busy=%0b exp 0/0", dropped, busy); end
    // Fresh window after the abort: leftover accumulation must be gone.
    en = 1'b1; win_len = 16'd2; threshold = 8'd0; match_in = 1'b0;
    @(negedge clk);
    match_in = 1'b0; @(negedge clk);
    match_in = 1'b1; @(negedge clk);
    match_in = 1'b0;
    checks++; if (count_valid !== 1'b1 || count_out !== 8'd1 || over_thresh !== 1'b1) begin
      errors++; $display("FAIL post_abort: got valid=%0b count=%0d over=%0b exp 1/1/1", count_valid, count_out, over_thresh); end
    count_ack = 1'b1; en = 1'b0; @(negedge clk); count_ack = 1'b0;
  endtask

  task automatic test_edge_lengths();
    for (int wl = 0; wl <= 1; wl++) begin
      en = 1'b1; win_len = 16'(wl); threshold = 8'd1; match_in = 1'b0;
      @(negedge clk);
      checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL edge_len%0d_early: got %0b exp 0", wl, count_valid); end
      match_in = 1'b1;
      @(negedge clk);
      match_in = 1'b0;
      checks++; if (count_valid !== 1'b1 || count_out !== 8'd1 || over_thresh !== 1'b1) begin
        errors++; $display("FAIL edge_len%0d: got valid=%0b count=%0d over=%0b exp 1/1/1", wl, count_valid, count_out, over_thresh); end
      count_ack = 1'b1; en = 1'b0; @(negedge clk); count_ack = 1'b0;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    en = 1'b1; win_len = 16'd20; threshold = 8'd21; threshold4 = 4'd15;
    @(negedge clk);
    for (int i = 1; i <= 20; i++) begin match_in = 1'b1; @(negedge clk); end
    match_in = 1'b0;
    checks++; if (count_out4 !== 4'd15 || overflow4 !== 1'b1 || over_thresh4 !== 1'b1 || count_valid4 !== 1'b1) begin
      errors++; $display("FAIL sat4: got count=%0d ovf=%0b over=%0b valid=%0b exp 15/1/1/1", count_out4, overflow4, over_thresh4, count_valid4); end
    checks++; if (count_out !== 8'd20 || overflow !== 1'b0 || over_thresh !== 1'b0) begin
      errors++; $display("FAIL sat8: got count=%0d ovf=%0b over=%0b exp 20/0/0", count_out, overflow, over_thresh); end
    count_ack = 1'b1; en = 1'b0; @(negedge clk); count_ack = 1'b0;
  endtask

  // Random windows chained back to back through HOLD, checked against a
  // count-of-matches model with clamping.
  task automatic test_back_to_back();
    int wl, len, sum, p, h;
    int thr8, thr4;
    int exp8, exp4;
    bit any;
    for (int w = 0; w < 40; w++) begin
      wl   = $urandom_range(0, 40);
      len  = (wl == 0) ? 1 : wl;
      thr8 = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 45);
      thr4 = $urandom_range(0, 15);
      p    = $urandom_range(0, 3);
      en = 1'b1; win_len = 16'(wl); threshold = 8'(thr8); threshold4 = 4'(thr4);
      count_ack = (w > 0); match_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      count_ack = 1'b0;
      checks++; if (busy !== 1'b1 || count_valid !== 1'b0 || dropped !== 1'b0) begin
        errors++; $display("FAIL b2b_start w%0d: got busy=%0b valid=%0b dropped=%0b exp 1/0/0", w, busy, count_valid, dropped); end
      sum = 0;
      for (int i = 1; i <= len; i++) begin
        match_in = ($urandom_range(0, 2) < p);
        sum += int'(match_in);
        win_len = 16'($urandom); threshold = 8'($urandom); threshold4 = 4'($urandom);
        @(negedge clk);
      end
      exp8 = (sum > 255) ? 255 : sum;
      exp4 = (sum > 15) ? 15 : sum;
      checks++; if (count_valid !== 1'b1 || busy !== 1'b0 || dropped !== 1'b0) begin
        errors++; $display("FAIL b2b_end w%0d: got valid=%0b busy=%0b dropped=%0b exp 1/0/0", w, count_valid, busy, dropped); end
      checks++; if (count_out !== 8'(exp8) || over_thresh !== (exp8 >= thr8) || overflow !== (sum > 255)) begin
        errors++; $display("FAIL b2b_res8 w%0d: got count=%0d over=%0b ovf=%0b exp %0d/%0b/%0b", w, count_out, over_thresh, overflow, exp8, exp8 >= thr8, sum > 255); end
      checks++; if (count_out4 !== 4'(exp4) || over_thresh4 !== (exp4 >= thr4) || overflow4 !== (sum > 15)) begin
        errors++; $display("FAIL b2b_res4 w%0d: got count=%0d over=%0b ovf=%0b exp %0d/%0b/%0b", w, count_out4, over_thresh4, overflow4, exp4, exp4 >= thr4, sum > 15); end
      h = $urandom_range(0, 3);
      any = 1'b0;
      for (int j = 0; j < h; j++) begin
        match_in = 1'($urandom_range(0, 1));
        any |= match_in;
        @(negedge clk);
        checks++; if (dropped !== any || count_out !== 8'(exp8) || count_valid !== 1'b1) begin
          errors++; $display("FAIL b2b_hold w%0d: got dropped=%0b count=%0d valid=%0b exp %0b/%0d/1", w, dropped, count_out, count_valid, any, exp8); end
      end
    end
    count_ack = 1'b1; en = 1'b0; match_in = 1'b0;
    @(negedge clk);
    count_ack = 1'b0;
    checks++; if (count_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_exit: got valid=%0b busy=%0b exp 0/0", count_valid, busy); end
  endtask

  task automatic test_async_reset();
    // Reset while a result is pending in HOLD.
    en = 1'b1; win_len = 16'd4; threshold = 8'd0;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin match_in = 1'b1; @(negedge clk); end
    count_ack = 1'b0; match_in = 1'b1;
    @(negedge clk);
    match_in = 1'b0;
    checks++; if (count_valid !== 1'b1 || count_out !== 8'd4 || dropped !== 1'b1) begin
      errors++; $display("FAIL pre_rst_hold: got valid=%0b count=%0d dropped=%0b exp 1/4/1", count_valid, count_out, dropped); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({count_out, count_valid, over_thresh, overflow, dropped, busy} !== 13'd0) begin
      errors++; $display("FAIL rst_hold: got %h exp 0", {count_out, count_valid, over_thresh, overflow, dropped, busy}); end
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0 || count_valid !== 1'b0) begin
      errors++; $display("FAIL rst_hold_idle: got busy=%0b valid=%0b exp 0/0", busy, count_valid); end
    // Reset in the middle of a counting window.
    en = 1'b1; win_len = 16'd10; threshold = 8'd2;
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin match_in = 1'b1; @(negedge clk); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_rst_count: got busy=%0b exp 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({count_out, count_valid, over_thresh, overflow, dropped, busy} !== 13'd0) begin
      errors++; $display("FAIL rst_count: got %h exp 0", {count_out, count_valid, over_thresh, overflow, dropped, busy}); end
    @(negedge clk);
    rst = 1'b0; en = 1'b0; match_in = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_wait_idle: got busy=%0b exp 0", busy); end
    en = 1'b1; win_len = 16'd2;
    @(negedge clk);
    match_in = 1'b1; @(negedge clk);
    match_in = 1'b1; @(negedge clk);
    match_in = 1'b0;
    checks++; if (count_valid !== 1'b1 || count_out !== 8'd2) begin
      errors++; $display("FAIL rst_fresh_window: got valid=%0b count=%0d exp 1/2", count_valid, count_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_handshake();
    test_abort();
    test_edge_lengths();
    test_saturation();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/match_window_counter.md
# match_window_counter

Downstream consumer of the serial pair-match detector. It counts the single-cycle match pulses that the detector's registered `outp` produces over a programmable window of clock cycles. At the end of each window it presents the count, a threshold flag and a saturation flag to the host through a valid/ack handshake. The block converts the raw per-bit match stream into a per-window statistic for status logic.

## Interface
- `CNT_W`, 8: width of the match accumulator and of `count_out` / `threshold`.
- `WIN_W`, 16: width of the window-length input.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clock `clk`.
- `en`  in  1  run enable; level-sensitive.
- `match_in`  in  1  match pulse, connected directly to the detector's registered `outp`.
- `win_len`  in  WIN_W  window length in cycles; sampled only at window start.
- `threshold`  in  CNT_W  compare value; sampled at window start.
- `count_ack`  in  1  host acknowledge of the current result.
- `count_out`  out  CNT_W  match count of the last completed window.
- `count_valid`  out  1  result pending; held until acknowledged.
- `over_thresh`  out  1  `count_out >= threshold` for the presented result.
- `overflow`  out  1  accumulator saturated during the presented window.
- `dropped`  out  1  sticky: a match arrived while no window was open (HOLD state); cleared only by `rst` or by the edge that starts the next window.
- `busy`  out  1  high in COUNT state.

## Operation
- The FSM has three states: IDLE, COUNT and HOLD. Reset enters IDLE.
- **IDLE:**
  - If `en`=1 at an edge, load `rem <= (win_len==0 ? 1 : win_len)`, clear `acc`, latch `threshold`, clear `dropped`, and go to COUNT.
  - `match_in` is ignored in IDLE.
- **COUNT:** at each edge:
  - `acc <= sat(acc + match_in)`, where `sat` clamps at 2^CNT_W−1.
  - If the add would exceed that maximum, set the window's overflow bit.
  - Decrement `rem`.
- **End of window:** the edge at which `rem`==1 ends the window.
  - Update `count_out` with the final `acc`, including this edge's `match_in`.
  - Set `over_thresh` and `overflow` for this result.
  - Set `count_valid`=1 and go to HOLD.
- **`en` dropped in COUNT:** if `en`=0 at any COUNT edge, abort. Go to IDLE, discard `acc`, and leave `count_out`/`count_valid` unchanged.
- **HOLD:** `count_out`, `over_thresh` and `overflow` stay stable while `count_valid`=1.
  - Each `match_in`=1 sets `dropped`.
  - At an edge with `count_ack`=1:
    - Clear `count_valid`.
    - If `en`=1, restart exactly as from IDLE, with no dead cycle beyond the HOLD cycle itself.
    - Otherwise go to IDLE.
- `count_ack` outside HOLD is ignored.
- `win_len` and `threshold` changes during COUNT have no effect on the running window.

## Timing
- **Reset values:** `count_out`=0, `count_valid`=0, `over_thresh`=0, `overflow`=0, `dropped`=0, `busy`=0. `acc`=0 and `rem`=0 internally.
- **Latency:** `en` is sampled high at edge E0 (IDLE). The window covers the `match_in` samples at edges E1..EL, where L is the effective length. `count_valid` rises after EL, i.e. L+1 edges after E0.
- **Back-to-back windows:** HOLD lasts at least 1 cycle. With `count_ack` tied high, windows repeat every L+1 cycles, and the match sampled in the HOLD cycle is dropped.
- **Boundary conditions:**
  - **`win_len`=0 or 1:** 1-cycle window.
  - **`win_len`=2^WIN_W−1:** full length, with no wrap.
  - **Saturation:** `acc` holds at its maximum and never wraps.
  - **`threshold`=0:** `over_thresh`=1 always.
- **`rst` mid-window or in HOLD:** outputs are immediately forced to their reset values, with no pending result retained.

## Test plan
- **Basic window:** `win_len`=8, `threshold`=3, `en`=1. Pulse `match_in` on window cycles 2, 4 and 8. Then `count_valid` rises 9 edges after `en` sampled, with `count_out`=3, `over_thresh`=1 and `overflow`=0.
- **Handshake hold:** leave `count_ack`=0 for 20 cycles with matches arriving in HOLD. `count_out` must stay stable and `dropped`=1. Pulse `count_ack` with `en`=1: `count_valid` falls, the next window starts, and `dropped` clears.
- **Saturation:** `CNT_W`=4, `win_len`=20, `match_in`=1 constantly. Expect `count_out`=15, `overflow`=1, `over_thresh`=1 for `threshold`=15.
- **Abort:** `win_len`=10, drop `en` at window cycle 5. FSM returns to IDLE, `count_valid` stays 0, and `count_out` keeps its previous value.
- **Edge lengths:** with `win_len`=0, `match_in`=1 at E1 gives `count_out`=1 after 2 edges. Repeat with `win_len`=1 for the same result.
- **Async reset:** assert `rst` mid-COUNT and in HOLD. All outputs must go to 0 without a clock edge, and after release the FSM waits in IDLE for `en`.
